// File: rtl/mc_ctrl_pkg.sv
// Shared state codes, opcode/funct constants and datapath select encodings for mc_ctrl and the MIPS datapath.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_ILLEGAL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JUMP = 2'd2;
  localparam logic [1:0] NPC_RS   = 2'd3;

  localparam logic [1:0] RFW_RT = 2'd0;
  localparam logic [1:0] RFW_RD = 2'd1;
  localparam logic [1:0] RFW_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, enables and selects out.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_rdy;
  logic       pcwr;
  logic       irwr;
  logic       regwr;
  logic       memwr;
  logic       memrd;
  logic [1:0] npc_sel;
  logic [1:0] rf_wsel;
  logic [1:0] wd_sel;
  logic       alu_srcb;
  logic [1:0] ext_op;
  logic [2:0] alu_op;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  op, funct, zero, mem_rdy,
    output pcwr, irwr, regwr, memwr, memrd, npc_sel, rf_wsel, wd_sel,
           alu_srcb, ext_op, alu_op, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_rdy,
    input  pcwr, irwr, regwr, memwr, memrd, npc_sel, rf_wsel, wd_sel,
           alu_srcb, ext_op, alu_op, illegal, state
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational op/funct decoder: instruction class plus the R-type ALU operation.
import mc_ctrl_pkg::*;

module mc_decode (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [2:0] ralu
);

  always_comb begin
    cls  = C_ILLEGAL;
    ralu = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        cls = C_RTYPE;
        case (funct)
          FN_ADDU: ralu = ALU_ADD;
          FN_SUBU: ralu = ALU_SUB;
          FN_SLT:  ralu = ALU_SLT;
          FN_AND:  ralu = ALU_AND;
          FN_OR:   ralu = ALU_OR;
          FN_JR:   cls  = C_JR;
          default: cls  = C_ILLEGAL;
        endcase
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB); Mealy enables, 2..5 cycles per instruction.
// MC_CTRL_MEMWAIT_EN: when defined, mem_rdy stretches FETCH and MEM; otherwise every access is one cycle.
import mc_ctrl_pkg::*;

module mc_ctrl (
  input  logic         clk,
  input  logic         rst,
  mc_ctrl_if.master    bus
);

  state_t     state_q, state_n;
  cls_t       cls;
  logic [2:0] ralu;
  logic       rdy;

  logic       srcb_x;
  logic [1:0] ext_x;
  logic [2:0] alu_x;

  mc_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (cls),
    .ralu  (ralu)
  );

`ifdef MC_CTRL_MEMWAIT_EN
  assign rdy = bus.mem_rdy;
`else
  // Memory is assumed single-cycle; the strobe is read but cannot stall.
  assign rdy = bus.mem_rdy | 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_n;
  end

  always_comb begin
    srcb_x = 1'b0;
    ext_x  = EXT_ZERO;
    alu_x  = ALU_ADD;
    case (cls)
      C_RTYPE: alu_x = ralu;
      C_ORI:   begin srcb_x = 1'b1; ext_x = EXT_ZERO; alu_x = ALU_OR;  end
      C_LUI:   begin srcb_x = 1'b1; ext_x = EXT_LUI;  alu_x = ALU_OR;  end
      C_LW,
      C_SW:    begin srcb_x = 1'b1; ext_x = EXT_SIGN; alu_x = ALU_ADD; end
      C_BEQ:   alu_x = ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    state_n      = state_q;
    bus.pcwr     = 1'b0;
    bus.irwr     = 1'b0;
    bus.regwr    = 1'b0;
    bus.memwr    = 1'b0;
    bus.memrd    = 1'b0;
    bus.npc_sel  = NPC_PC4;
    bus.rf_wsel  = RFW_RT;
    bus.wd_sel   = WD_ALU;
    bus.alu_srcb = 1'b0;
    bus.ext_op   = EXT_ZERO;
    bus.alu_op   = ALU_ADD;
    bus.illegal  = 1'b0;

    // Selects stay at their EXE values through MEM and WB.
    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      bus.alu_srcb = srcb_x;
      bus.ext_op   = ext_x;
      bus.alu_op   = alu_x;
    end

    case (state_q)
      S_FETCH: begin
        bus.memrd = 1'b1;
        if (rdy) begin
          bus.irwr = 1'b1;
          bus.pcwr = 1'b1;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        state_n = S_EXE;
        case (cls)
          C_J: begin
            bus.pcwr    = 1'b1;
            bus.npc_sel = NPC_JUMP;
            state_n     = S_FETCH;
          end
          C_JAL: begin
            bus.pcwr    = 1'b1;
            bus.npc_sel = NPC_JUMP;
            bus.regwr   = 1'b1;
            bus.rf_wsel = RFW_RA;
            bus.wd_sel  = WD_PC4;
            state_n     = S_FETCH;
          end
          C_JR: begin
            bus.pcwr    = 1'b1;
            bus.npc_sel = NPC_RS;
            state_n     = S_FETCH;
          end
          C_ILLEGAL: begin
            bus.illegal = 1'b1;
            state_n     = S_FETCH;
          end
          default: ;
        endcase
      end
      S_EXE: begin
        case (cls)
          C_BEQ: begin
            bus.pcwr    = bus.zero;
            bus.npc_sel = NPC_BR;
            state_n     = S_FETCH;
          end
          C_RTYPE, C_ORI, C_LUI: state_n = S_WB;
          C_LW, C_SW:            state_n = S_MEM;
          default:               state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (cls == C_LW) bus.memrd = 1'b1;
        else             bus.memwr = 1'b1;
        if (rdy) state_n = (cls == C_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        bus.regwr   = 1'b1;
        bus.wd_sel  = (cls == C_LW)    ? WD_MEM : WD_ALU;
        bus.rf_wsel = (cls == C_RTYPE) ? RFW_RD : RFW_RT;
        state_n     = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase

    // Reset kills any in-flight enable immediately, not just at the next edge.
    if (rst) begin
      state_n      = S_FETCH;
      bus.pcwr     = 1'b0;
      bus.irwr     = 1'b0;
      bus.regwr    = 1'b0;
      bus.memwr    = 1'b0;
      bus.memrd    = 1'b0;
      bus.npc_sel  = NPC_PC4;
      bus.rf_wsel  = RFW_RT;
      bus.wd_sel   = WD_ALU;
      bus.alu_srcb = 1'b0;
      bus.ext_op   = EXT_ZERO;
      bus.alu_op   = ALU_ADD;
      bus.illegal  = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction cycle-by-cycle checks of enables, selects and state.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {pcwr, irwr, regwr, memwr, memrd, npc_sel, rf_wsel, wd_sel, alu_srcb, ext_op, alu_op, illegal}
  wire [17:0] ctl = {bus.pcwr, bus.irwr, bus.regwr, bus.memwr, bus.memrd, bus.npc_sel,
                     bus.rf_wsel, bus.wd_sel, bus.alu_srcb, bus.ext_op, bus.alu_op, bus.illegal};

  function automatic logic [17:0] pk(input logic pcwr, input logic irwr, input logic regwr,
                                     input logic memwr, input logic memrd, input logic [1:0] npc,
                                     input logic [1:0] rfw, input logic [1:0] wd, input logic srcb,
                                     input logic [1:0] ext, input logic [2:0] alu, input logic ill);
    return {pcwr, irwr, regwr, memwr, memrd, npc, rfw, wd, srcb, ext, alu, ill};
  endfunction

  localparam logic [17:0] FETCH_CTL = 18'b1_1_0_0_1_00_00_00_0_00_000_0;

`ifdef MC_CTRL_MEMWAIT_EN
  localparam int LW_CYCLES = 7;
  localparam int LW_MEMCYC = 3;
`else
  localparam int LW_CYCLES = 5;
  localparam int LW_MEMCYC = 1;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++;
    if (ctl !== 18'h0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", ctl); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== FETCH_CTL) begin n_bad++; $display("FAIL reset_first_fetch: got %h want %h", ctl, FETCH_CTL); end
  endtask

  task automatic test_addu;
    bus.op = 6'h00; bus.funct = 6'h21;
    n_cmp++;
    if (ctl !== FETCH_CTL) begin n_bad++; $display("FAIL addu_c0: got %h want %h", ctl, FETCH_CTL); end
    tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd1, 18'h0}) begin n_bad++; $display("FAIL addu_c1: got %h want %h", {bus.state, ctl}, {3'd1, 18'h0}); end
    tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd2, 18'h0}) begin n_bad++; $display("FAIL addu_c2: got %h want %h", {bus.state, ctl}, {3'd2, 18'h0}); end
    tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd4, pk(0,0,1,0,0,0,1,0,0,0,0,0)}) begin
      n_bad++; $display("FAIL addu_wb: got %h want %h", {bus.state, ctl}, {3'd4, pk(0,0,1,0,0,0,1,0,0,0,0,0)});
    end
    tick;
    n_cmp++;
    if (bus.state !== 3'd0) begin n_bad++; $display("FAIL addu_c4: got %0d want 0", bus.state); end
  endtask

  task automatic test_lw;
    int cyc, memcnt;
    bus.op = 6'h23; bus.funct = 6'h04; bus.mem_rdy = 1'b1;
    tick; tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd2, pk(0,0,0,0,0,0,0,0,1,1,0,0)}) begin
      n_bad++; $display("FAIL lw_exe: got %h want %h", {bus.state, ctl}, {3'd2, pk(0,0,0,0,0,0,0,0,1,1,0,0)});
    end
    tick;
    cyc = 3; memcnt = 0;
    while (bus.state !== 3'd0 && cyc < 20) begin
      if (bus.state === 3'd3) begin
        memcnt++;
`ifdef MC_CTRL_MEMWAIT_EN
        bus.mem_rdy = (memcnt >= 3);
`else
        bus.mem_rdy = 1'b0;
`endif
        #0;
        n_cmp++;
        if (ctl !== pk(0,0,0,0,1,0,0,0,1,1,0,0)) begin
          n_bad++; $display("FAIL lw_mem: got %h want %h", ctl, pk(0,0,0,0,1,0,0,0,1,1,0,0));
        end
      end else if (bus.state === 3'd4) begin
        n_cmp++;
        if (ctl !== pk(0,0,1,0,0,0,0,1,1,1,0,0)) begin
          n_bad++; $display("FAIL lw_wb: got %h want %h", ctl, pk(0,0,1,0,0,0,0,1,1,1,0,0));
        end
      end
      tick;
      cyc++;
    end
    bus.mem_rdy = 1'b1;
    n_cmp++;
    if (cyc !== LW_CYCLES) begin n_bad++; $display("FAIL lw_cycles: got %0d want %0d", cyc, LW_CYCLES); end
    n_cmp++;
    if (memcnt !== LW_MEMCYC) begin n_bad++; $display("FAIL lw_mem_cycles: got %0d want %0d", memcnt, LW_MEMCYC); end
  endtask

  task automatic test_beq(input logic z);
    bus.op = 6'h04; bus.funct = 6'h02; bus.zero = z;
    tick; tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd2, pk(z,0,0,0,0,1,0,0,0,0,1,0)}) begin
      n_bad++; $display("FAIL beq_exe z=%0d: got %h want %h", z, {bus.state, ctl}, {3'd2, pk(z,0,0,0,0,1,0,0,0,0,1,0)});
    end
    tick;
    n_cmp++;
    if (bus.state !== 3'd0) begin n_bad++; $display("FAIL beq_cycles z=%0d: state %0d want 0", z, bus.state); end
    bus.zero = 1'b0;
  endtask

  task automatic test_jal;
    bus.op = 6'h03; bus.funct = 6'h10;
    tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd1, pk(1,0,1,0,0,2,2,2,0,0,0,0)}) begin
      n_bad++; $display("FAIL jal_decode: got %h want %h", {bus.state, ctl}, {3'd1, pk(1,0,1,0,0,2,2,2,0,0,0,0)});
    end
    tick;
    n_cmp++;
    if (bus.state !== 3'd0) begin n_bad++; $display("FAIL jal_next: got %0d want 0", bus.state); end
  endtask

  task automatic test_jr;
    bus.op = 6'h00; bus.funct = 6'h08;
    tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd1, pk(1,0,0,0,0,3,0,0,0,0,0,0)}) begin
      n_bad++; $display("FAIL jr_decode: got %h want %h", {bus.state, ctl}, {3'd1, pk(1,0,0,0,0,3,0,0,0,0,0,0)});
    end
    tick;
    n_cmp++;
    if (bus.state !== 3'd0) begin n_bad++; $display("FAIL jr_next: got %0d want 0", bus.state); end
  endtask

  task automatic test_ori_lui;
    bus.op = 6'h0D; bus.funct = 6'h05;
    tick; tick;
    n_cmp++;
    if (ctl !== pk(0,0,0,0,0,0,0,0,1,0,2,0)) begin n_bad++; $display("FAIL ori_exe: got %h want %h", ctl, pk(0,0,0,0,0,0,0,0,1,0,2,0)); end
    tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd4, pk(0,0,1,0,0,0,0,0,1,0,2,0)}) begin
      n_bad++; $display("FAIL ori_wb: got %h want %h", {bus.state, ctl}, {3'd4, pk(0,0,1,0,0,0,0,0,1,0,2,0)});
    end
    tick;
    bus.op = 6'h0F; bus.funct = 6'h34;
    tick; tick;
    n_cmp++;
    if (ctl !== pk(0,0,0,0,0,0,0,0,1,2,2,0)) begin n_bad++; $display("FAIL lui_exe: got %h want %h", ctl, pk(0,0,0,0,0,0,0,0,1,2,2,0)); end
    tick;
    n_cmp++;
    if (ctl !== pk(0,0,1,0,0,0,0,0,1,2,2,0)) begin n_bad++; $display("FAIL lui_wb: got %h want %h", ctl, pk(0,0,1,0,0,0,0,0,1,2,2,0)); end
    tick;
  endtask

  task automatic test_illegal;
    bus.op = 6'h3F; bus.funct = 6'h00;
    tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd1, pk(0,0,0,0,0,0,0,0,0,0,0,1)}) begin
      n_bad++; $display("FAIL illegal_decode: got %h want %h", {bus.state, ctl}, {3'd1, pk(0,0,0,0,0,0,0,0,0,0,0,1)});
    end
    tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd0, FETCH_CTL}) begin
      n_bad++; $display("FAIL illegal_next: got %h want %h", {bus.state, ctl}, {3'd0, FETCH_CTL});
    end
  endtask

  task automatic test_sw_reset;
    bus.op = 6'h2B; bus.funct = 6'h04;
    tick; tick; tick;
    n_cmp++;
    if ({bus.state, ctl} !== {3'd3, pk(0,0,0,1,0,0,0,0,1,1,0,0)}) begin
      n_bad++; $display("FAIL sw_mem: got %h want %h", {bus.state, ctl}, {3'd3, pk(0,0,0,1,0,0,0,0,1,1,0,0)});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.state, ctl} !== 21'h0) begin n_bad++; $display("FAIL sw_abort: got %h want 0", {bus.state, ctl}); end
    tick;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.state, bus.memrd} !== {3'd0, 1'b1}) begin
      n_bad++; $display("FAIL sw_release: got %h want %h", {bus.state, bus.memrd}, {3'd0, 1'b1});
    end
    tick;
    n_cmp++;
    if (bus.state !== 3'd1) begin n_bad++; $display("FAIL sw_resume: got %0d want 1", bus.state); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_rdy = 1'b1;
    test_reset;
    test_addu;
    test_lw;
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal;
    test_jr;
    test_ori_lui;
    test_illegal;
    test_sw_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
